attn_sv_matmul: RTL
===================

# attn_sv_matmul

Downstream attention stage that consumes the score matrix S (N×N) and value matrix V (N×D) already written to result SRAM by the QKV/score engine, and produces Z = S·V (N×D) back into result SRAM. It shares the single result-SRAM read port and write port, fetches S and V words alternately, and accumulates one Z element at a time. It is started by a valid/ready handshake once the score engine reports done, and signals completion with a one-cycle `done` pulse.

## Interface
- `DATA_W`, 32, SRAM word width and accumulator width
- `ADDR_W`, 32, SRAM address width
- `DIM_W`, 16, width of the N and D dimension inputs
- `clk`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start_valid`  in  1  request to start; config inputs sampled when `start_valid && start_ready`
- `start_ready`  out  1  high exactly when the FSM is in IDLE
- `n_rows`  in  DIM_W  N: S is N×N, V has N rows
- `n_cols`  in  DIM_W  D: V and Z have D columns
- `s_base`, `v_base`, `z_base`  in  ADDR_W  row-major base word addresses of S, V and Z
- `sram_read_address`  out  ADDR_W  result-SRAM read address; data returns on the next cycle
- `sram_read_data`  in  DATA_W  result-SRAM read data
- `sram_write_enable`  out  1  result-SRAM write strobe
- `sram_write_address`  out  ADDR_W  result-SRAM write address
- `sram_write_data`  out  DATA_W  result-SRAM write data
- `done`  out  1  one-cycle pulse after the last Z word is written

## Operation
- Z[i][j] = Σₖ S[i][k]·V[k][j]. Addresses: S at s_base+i·N+k, V at v_base+k·D+j, Z at z_base+i·D+j.
- Output order: i outer, j inner, k innermost.
- Arithmetic: unsigned, product truncated to DATA_W, accumulation modulo 2^DATA_W with no saturation.
- Address generation uses running pointers with no multipliers:
  - s_ptr increments per k and rewinds to the row start at end of k.
  - v_ptr adds D per k and resets to v_base+j+1 at end of k.
  - z_ptr increments per write.
- Overlapping S/V/Z regions are the caller's problem and are not checked.
- FSM states:
  - IDLE: `start_ready`=1. On handshake, latch N, D and the bases, clear i/j/k, acc and pend. If N==0 or D==0, go to DONE; otherwise go to RD_S.
  - RD_S: read address = S(i,k). If pend, acc ← acc + s_reg·sram_read_data (this is the V of the previous k). Next state RD_V.
  - RD_V: read address = V(k,j). s_reg ← sram_read_data. pend ← 1. If k==N−1, go to DRAIN; otherwise k++ and go to RD_S.
  - DRAIN: `sram_write_enable`=1, write address = z_ptr, write data = acc + s_reg·sram_read_data (combinational). Then acc ← 0, pend ← 0, k ← 0, advance j, wrapping j to 0 and incrementing i. Go to DONE after the last element (i==N−1, j==D−1); otherwise go to RD_S.
  - DONE: `done`=1 for one cycle, then IDLE.
- `start_valid` outside IDLE is ignored, and config inputs may change freely while busy.
- `sram_read_address` is driven to 0 in IDLE, DRAIN and DONE.

## Timing
- Reset values: `start_ready`=1 (IDLE), `done`=0, `sram_write_enable`=0, `sram_read_address`=0, `sram_write_address`=0, `sram_write_data`=0. All internal registers clear to 0.
- Asserting reset mid-operation aborts immediately. No further writes occur, no `done` pulse is produced, and the block returns to IDLE.
- Call the handshake edge cycle 0:
  - the first RD_S occurs in cycle 1;
  - each Z element takes 2N+1 cycles;
  - `done` is asserted in cycle N·D·(2N+1)+1;
  - `start_ready` rises the cycle after that.
- Degenerate case N==0 or D==0: `done` in cycle 1, with no reads and no writes.
- Read latency is fixed at exactly one cycle, with no stall input. Data for the address driven in cycle t is consumed in cycle t+1.
- Back-to-back jobs: the earliest next handshake is the cycle after `done`.

## Structure
- Shared package `attn_pkg`:
  - `e_sv_state` enum (IDLE, RD_S, RD_V, DRAIN, DONE), 3 bits;
  - width localparams DATA_W, ADDR_W, DIM_W, matching the common SRAM range macros.
- One sub-module, `attn_sv_addr_gen`. It holds the i/j/k counters and the s/v/z pointers, and provides last-k and last-element flags. The FSM and MAC datapath stay in the top module.

## Test plan
- N=2, D=2, S=[[1,0],[0,1]], V=[[5,6],[7,8]] at s_base=0, v_base=4, z_base=8 -> writes 5,6,7,8 to addresses 8..11 in that order; `done` in cycle 21.
- N=2, D=3, S=[[1,2],[3,4]], V=[[1,2,3],[4,5,6]] -> Z=[[9,12,15],[19,26,33]] written to z_base..z_base+5; `done` in cycle 31.
- N=1, D=1, S=[0xFFFFFFFF], V=[2] -> writes 0xFFFFFFFE (wrap) in cycle 3; `done` in cycle 4.
- N=0 with `start_valid` high -> no read or write activity; `done` in cycle 1; `start_ready` back to 1 in cycle 2.
- Reset asserted during the second DRAIN of the 2×2 case -> at most one Z write (address 8) observed; all outputs return to reset values immediately; no `done`; a new job afterwards completes correctly.
- `start_valid` held high continuously across two jobs with different bases -> the second job starts the cycle after the first `done`; config changes made mid-job do not affect the running job.

Source files
------------

// File: rtl/attn_sv_matmul_pkg.sv
// Shared types and widths for the attention S*V matmul stage.
package attn_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DIM_W  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_S  = 3'd1,
        RD_V  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } e_sv_state;

endpackage

// File: rtl/attn_sv_matmul_if.sv
// Start handshake, job configuration and result-SRAM port of the S*V stage.
interface attn_sv_matmul_if import attn_pkg::*; ();

    logic              start_valid;
    logic              start_ready;
    logic [DIM_W-1:0]  n_rows;
    logic [DIM_W-1:0]  n_cols;
    logic [ADDR_W-1:0] s_base;
    logic [ADDR_W-1:0] v_base;
    logic [ADDR_W-1:0] z_base;
    logic [ADDR_W-1:0] sram_read_address;
    logic [DATA_W-1:0] sram_read_data;
    logic              sram_write_enable;
    logic [ADDR_W-1:0] sram_write_address;
    logic [DATA_W-1:0] sram_write_data;
    logic              done;

    // Requester / SRAM side
    modport master (
        output start_valid, n_rows, n_cols, s_base, v_base, z_base, sram_read_data,
        input  start_ready, sram_read_address, sram_write_enable,
               sram_write_address, sram_write_data, done
    );

    // Matmul engine side
    modport slave (
        input  start_valid, n_rows, n_cols, s_base, v_base, z_base, sram_read_data,
        output start_ready, sram_read_address, sram_write_enable,
               sram_write_address, sram_write_data, done
    );

endinterface

// File: rtl/attn_sv_matmul_addr_gen.sv
// i/j/k loop counters and S/V/Z running pointers; adders only, no multipliers.
module attn_sv_addr_gen import attn_pkg::*; (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic [DIM_W-1:0]  i_n,
    input  logic [DIM_W-1:0]  i_d,
    input  logic [ADDR_W-1:0] i_s_base,
    input  logic [ADDR_W-1:0] i_v_base,
    input  logic [ADDR_W-1:0] i_z_base,
    input  logic              i_k_adv,
    input  logic              i_elem_adv,
    output logic [ADDR_W-1:0] o_s_ptr,
    output logic [ADDR_W-1:0] o_v_ptr,
    output logic [ADDR_W-1:0] o_z_ptr,
    output logic              o_last_k,
    output logic              o_last_elem
);

    logic [DIM_W-1:0]  r_n, r_d, r_i, r_j, r_k;
    logic [ADDR_W-1:0] r_s_row;   // S address of (i, 0)
    logic [ADDR_W-1:0] r_s_ptr;
    logic [ADDR_W-1:0] r_v_base;
    logic [ADDR_W-1:0] r_v_col;   // V address of (0, j)
    logic [ADDR_W-1:0] r_v_ptr;
    logic [ADDR_W-1:0] r_z_ptr;

    logic [ADDR_W-1:0] w_n_ext, w_d_ext;
    logic              w_last_j;

    assign w_n_ext     = {{(ADDR_W-DIM_W){1'b0}}, r_n};
    assign w_d_ext     = {{(ADDR_W-DIM_W){1'b0}}, r_d};
    assign w_last_j    = (r_j == r_d - DIM_W'(1));
    assign o_last_k    = (r_k == r_n - DIM_W'(1));
    assign o_last_elem = (r_i == r_n - DIM_W'(1)) && w_last_j;
    assign o_s_ptr     = r_s_ptr;
    assign o_v_ptr     = r_v_ptr;
    assign o_z_ptr     = r_z_ptr;

    // Latch job geometry on start, then step k per S/V pair and (i,j) per Z element
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_n      <= '0;
            r_d      <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_s_row  <= '0;
            r_s_ptr  <= '0;
            r_v_base <= '0;
            r_v_col  <= '0;
            r_v_ptr  <= '0;
            r_z_ptr  <= '0;
        end else if (i_load) begin
            r_n      <= i_n;
            r_d      <= i_d;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_s_row  <= i_s_base;
            r_s_ptr  <= i_s_base;
            r_v_base <= i_v_base;
            r_v_col  <= i_v_base;
            r_v_ptr  <= i_v_base;
            r_z_ptr  <= i_z_base;
        end else if (i_k_adv) begin
            r_k     <= r_k + DIM_W'(1);
            r_s_ptr <= r_s_ptr + ADDR_W'(1);
            r_v_ptr <= r_v_ptr + w_d_ext;
        end else if (i_elem_adv) begin
            r_k     <= '0;
            r_z_ptr <= r_z_ptr + ADDR_W'(1);
            if (w_last_j) begin
                // next output row: S moves down one row, V back to column 0
                r_j     <= '0;
                r_i     <= r_i + DIM_W'(1);
                r_s_row <= r_s_row + w_n_ext;
                r_s_ptr <= r_s_row + w_n_ext;
                r_v_col <= r_v_base;
                r_v_ptr <= r_v_base;
            end else begin
                r_j     <= r_j + DIM_W'(1);
                r_s_ptr <= r_s_row;
                r_v_col <= r_v_col + ADDR_W'(1);
                r_v_ptr <= r_v_col + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/attn_sv_matmul.sv
// Z = S*V over the shared result SRAM: alternate S/V reads, one MAC per k,
// one Z write per (i,j).
module attn_sv_matmul import attn_pkg::*; (
    input  logic       clk,
    input  logic       reset_n,
    attn_sv_matmul_if.slave bus
);

    e_sv_state         r_state;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_s_reg;
    logic              r_pend;    // r_s_reg holds an S whose V arrives this cycle

    logic              w_empty, w_load, w_k_adv, w_elem_adv;
    logic              w_last_k, w_last_elem;
    logic [ADDR_W-1:0] w_s_ptr, w_v_ptr, w_z_ptr;
    logic [DATA_W-1:0] w_prod, w_sum;

    assign w_empty    = (bus.n_rows == '0) || (bus.n_cols == '0);
    assign w_load     = (r_state == IDLE) && bus.start_valid;
    assign w_k_adv    = (r_state == RD_V) && !w_last_k;
    assign w_elem_adv = (r_state == DRAIN);

    // product truncates to DATA_W; accumulation wraps modulo 2^DATA_W
    assign w_prod = r_s_reg * bus.sram_read_data;
    assign w_sum  = r_acc + w_prod;

    attn_sv_addr_gen u_addr_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_load),
        .i_n         (bus.n_rows),
        .i_d         (bus.n_cols),
        .i_s_base    (bus.s_base),
        .i_v_base    (bus.v_base),
        .i_z_base    (bus.z_base),
        .i_k_adv     (w_k_adv),
        .i_elem_adv  (w_elem_adv),
        .o_s_ptr     (w_s_ptr),
        .o_v_ptr     (w_v_ptr),
        .o_z_ptr     (w_z_ptr),
        .o_last_k    (w_last_k),
        .o_last_elem (w_last_elem)
    );

    assign bus.start_ready        = (r_state == IDLE);
    assign bus.done               = (r_state == DONE);
    assign bus.sram_write_enable  = (r_state == DRAIN);
    assign bus.sram_write_address = (r_state == DRAIN) ? w_z_ptr : '0;
    assign bus.sram_write_data    = (r_state == DRAIN) ? w_sum   : '0;

    // Read address follows the phase: S in RD_S, V in RD_V, parked at 0 otherwise
    always_comb begin
        bus.sram_read_address = '0;
        case (r_state)
            RD_S:    bus.sram_read_address = w_s_ptr;
            RD_V:    bus.sram_read_address = w_v_ptr;
            default: bus.sram_read_address = '0;
        endcase
    end

    // Control FSM with MAC: S is captured in RD_V, multiplied by V in the next RD_S or DRAIN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_s_reg <= '0;
            r_pend  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start_valid) begin
                        r_acc   <= '0;
                        r_pend  <= 1'b0;
                        r_state <= w_empty ? DONE : RD_S;
                    end
                end
                RD_S: begin
                    if (r_pend) r_acc <= w_sum;
                    r_state <= RD_V;
                end
                RD_V: begin
                    r_s_reg <= bus.sram_read_data;
                    r_pend  <= 1'b1;
                    r_state <= w_last_k ? DRAIN : RD_S;
                end
                DRAIN: begin
                    r_acc   <= '0;
                    r_pend  <= 1'b0;
                    r_state <= w_last_elem ? DONE : RD_S;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
